// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 800x600@60 timing defaults and the line-fetch FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int C_H_VISIBLE = 800;
  localparam int C_H_FRONT   = 40;
  localparam int C_H_SYNC    = 128;
  localparam int C_H_BACK    = 88;

  localparam int C_V_VISIBLE = 600;
  localparam int C_V_FRONT   = 1;
  localparam int C_V_SYNC    = 4;
  localparam int C_V_BACK    = 23;

  typedef enum logic [0:0] {
    F_IDLE = 1'b0,
    F_REQ  = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Brief    : One timing axis: wrapping counter plus flags for its next value.
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
  parameter int VISIBLE = 800,
  parameter int FRONT   = 40,
  parameter int SYNC    = 128,
  parameter int BACK    = 88,
  parameter int W       = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_adv,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_next_visible,
  output logic         o_next_sync,
  output logic         o_terminal
);

  localparam int           C_TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] C_LAST       = W'(C_TOTAL - 1);
  localparam logic [W-1:0] C_ONE        = W'(1);
  localparam logic [W-1:0] C_VIS        = W'(VISIBLE);
  localparam logic [W-1:0] C_SYNC_START = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] C_SYNC_END   = W'(VISIBLE + FRONT + SYNC);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;
  logic         w_terminal;

  assign w_terminal = (r_count == C_LAST);

  always_comb begin
    w_next = r_count;
    if (i_clr) begin
      w_next = '0;
    end else if (i_adv) begin
      w_next = w_terminal ? '0 : r_count + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  // Flags describe the value about to be loaded so the parent can register them alongside it
  assign o_count        = r_count;
  assign o_next         = w_next;
  assign o_terminal     = w_terminal;
  assign o_next_visible = (w_next < C_VIS);
  assign o_next_sync    = (w_next >= C_SYNC_START) && (w_next < C_SYNC_END);

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Brief    : VGA sync/DE/coordinate generator with per-line fetch scheduling
//            and a sticky underrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = C_H_VISIBLE,
  parameter int H_FRONT   = C_H_FRONT,
  parameter int H_SYNC    = C_H_SYNC,
  parameter int H_BACK    = C_H_BACK,
  parameter int V_VISIBLE = C_V_VISIBLE,
  parameter int V_FRONT   = C_V_FRONT,
  parameter int V_SYNC    = C_V_SYNC,
  parameter int V_BACK    = C_V_BACK,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int HW        = 11,
  parameter int VW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          fetch_ack,
  input  logic          underrun_clr,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_req,
  output logic [VW-1:0] fetch_line,
  output logic          underrun
);

  localparam logic [HW-1:0] C_H_ISSUE = HW'(H_VISIBLE);
  localparam logic [VW-1:0] C_V_VIS   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] C_V_ONE   = VW'(1);

  logic          r_running;
  logic          w_run;
  logic [HW-1:0] w_h_count, w_h_next;
  logic [VW-1:0] w_v_count, w_v_next;
  logic          w_h_vis, w_h_sync, w_h_tc;
  logic          w_v_vis, w_v_sync, w_v_tc;
  logic          w_wrap, w_issue, w_set;
  logic [VW-1:0] w_line_n;
  fetch_state_t  r_state, w_state_nxt;
  logic [VW-1:0] r_fetch_line;
  logic          r_underrun, r_de, r_hsync, r_vsync, r_line_start, r_frame_start;

  // The first enabled cycle only restarts at (0,0); counting starts the cycle after
  assign w_run = enable & r_running;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(HW)
  ) u_h_axis (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clr          (~enable),
    .i_adv          (w_run),
    .o_count        (w_h_count),
    .o_next         (w_h_next),
    .o_next_visible (w_h_vis),
    .o_next_sync    (w_h_sync),
    .o_terminal     (w_h_tc)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(VW)
  ) u_v_axis (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_clr          (~enable),
    .i_adv          (w_run & w_h_tc),
    .o_count        (w_v_count),
    .o_next         (w_v_next),
    .o_next_visible (w_v_vis),
    .o_next_sync    (w_v_sync),
    .o_terminal     (w_v_tc)
  );

  assign w_wrap   = w_run & w_h_tc;
  assign w_line_n = w_v_tc ? '0 : w_v_count + C_V_ONE;
  assign w_issue  = w_run & (w_h_next == C_H_ISSUE) & (w_line_n < C_V_VIS);

  // An ack landing on the deadline edge wins over the underrun
  always_comb begin
    w_state_nxt = r_state;
    w_set       = 1'b0;
    if (!enable) begin
      w_state_nxt = F_IDLE;
    end else if (r_state == F_REQ) begin
      if (fetch_ack) begin
        w_state_nxt = F_IDLE;
      end else if (w_wrap) begin
        w_state_nxt = F_IDLE;
        w_set       = 1'b1;
      end
    end else if (w_issue) begin
      w_state_nxt = F_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running     <= 1'b0;
      r_state       <= F_IDLE;
      r_fetch_line  <= '0;
      r_underrun    <= 1'b0;
      r_de          <= 1'b0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_running <= enable;
      r_state   <= w_state_nxt;
      if ((r_state == F_IDLE) && (w_state_nxt == F_REQ)) begin
        r_fetch_line <= w_line_n;
      end
      if (w_set) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
      r_de          <= enable & w_h_vis & w_v_vis;
      r_hsync       <= (enable & w_h_sync) ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= (enable & w_v_sync) ? VSYNC_POL : ~VSYNC_POL;
      r_line_start  <= enable & (w_h_next == '0);
      r_frame_start <= enable & (w_h_next == '0) & (w_v_next == '0);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = w_h_count;
  assign y           = w_v_count;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign fetch_req   = (r_state == F_REQ);
  assign fetch_line  = r_fetch_line;
  assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Brief    : Bench for vga_timing_ctrl: default and reduced timing instances
//            checked every cycle against a frame-position model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

  localparam int S_HV = 8, S_HF = 2, S_HS = 2, S_HB = 2;
  localparam int S_VV = 4, S_VF = 1, S_VS = 1, S_VB = 1;

  typedef struct {
    bit run;
    int h;
    int v;
    bit pend;
    int line;
    bit ur;
    bit de, hs, vs, ls, fs;
  } mdl_t;

  logic clk, rst_n;
  logic b_en, b_ack, b_clr, s_en, s_ack, s_clr;
  logic b_hs, b_vs, b_de, b_ls, b_fs, b_req, b_ur;
  logic s_hs, s_vs, s_de, s_ls, s_fs, s_req, s_ur;
  logic [10:0] b_x;
  logic [9:0]  b_y, b_line;
  logic [3:0]  s_x;
  logic [2:0]  s_y, s_line;

  int n_checks = 0;
  int n_err    = 0;
  mdl_t mb, ms;

  vga_timing_ctrl u_big (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .fetch_ack(b_ack), .underrun_clr(b_clr),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
    .line_start(b_ls), .frame_start(b_fs), .fetch_req(b_req), .fetch_line(b_line),
    .underrun(b_ur)
  );

  vga_timing_ctrl #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .HW(4), .VW(3)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .enable(s_en), .fetch_ack(s_ack), .underrun_clr(s_clr),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .fetch_req(s_req), .fetch_line(s_line),
    .underrun(s_ur)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic mdl_t mreset();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  // Position-based model: where the beam is, and whether a line request is open
  function automatic mdl_t step(input mdl_t m, input int hv, hf, hs, hb, vv, vf, vs, vb,
                                input bit en, ack, clr);
    mdl_t n;
    int   ht, vt;
    bit   set;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    n   = m;
    set = 1'b0;
    if (!en) begin
      n.run = 0; n.h = 0; n.v = 0; n.pend = 0;
    end else begin
      if (!m.run) begin
        n.run = 1; n.h = 0; n.v = 0;
      end else begin
        n.h = (m.h + 1) % ht;
        if (n.h == 0) n.v = (m.v + 1) % vt;
      end
      if (m.pend) begin
        if (ack) n.pend = 0;
        else if (m.run && n.h == 0) begin n.pend = 0; set = 1; end
      end else if (m.run && n.h == hv && ((n.v + 1) % vt) < vv) begin
        n.pend = 1;
        n.line = (n.v + 1) % vt;
      end
    end
    n.ur = set ? 1'b1 : (clr ? 1'b0 : m.ur);
    n.de = en && n.h < hv && n.v < vv;
    n.hs = en && n.h >= hv + hf && n.h < hv + hf + hs;
    n.vs = en && n.v >= vv + vf && n.v < vv + vf + vs;
    n.ls = en && n.h == 0;
    n.fs = en && n.h == 0 && n.v == 0;
    return n;
  endfunction

  task automatic cmp(input string t, input mdl_t m, input bit vpol,
                     input bit a_hs, a_vs, a_de, input int a_x, a_y,
                     input bit a_ls, a_fs, a_req, input int a_line, input bit a_ur);
    chk({t, "_hsync"}, a_hs, m.hs ? 1 : 0);
    chk({t, "_vsync"}, a_vs, m.vs ? vpol : !vpol);
    chk({t, "_de"}, a_de, m.de);
    chk({t, "_x"}, a_x, m.h);
    chk({t, "_y"}, a_y, m.v);
    chk({t, "_line_start"}, a_ls, m.ls);
    chk({t, "_frame_start"}, a_fs, m.fs);
    chk({t, "_fetch_req"}, a_req, m.pend);
    chk({t, "_fetch_line"}, a_line, m.line);
    chk({t, "_underrun"}, a_ur, m.ur);
  endtask

  // Per-cycle compare against the model
  initial begin
    mb = mreset();
    ms = mreset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mb = mreset();
        ms = mreset();
      end else begin
        mb = step(mb, 800, 40, 128, 88, 600, 1, 4, 23, b_en, b_ack, b_clr);
        ms = step(ms, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, s_en, s_ack, s_clr);
      end
      #1;
      cmp("big", mb, 1'b1, b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs, b_req, b_line, b_ur);
      cmp("small", ms, 1'b0, s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_req, s_line, s_ur);
    end
  end

  // Default-timing memory side acks a fixed delay after each request
  initial begin
    int w;
    w = 0;
    b_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (b_req && !b_ack) begin
        w++;
        if (w == 10) b_ack = 1'b1;
      end else begin
        b_ack = 1'b0;
        w = 0;
      end
    end
  end

  // Statistics of the default-timing instance for literal checks
  int cyc = 0, b_ls_cnt = 0, b_ls_prev = 0, b_period = 0, b_fs_cnt = 0;
  int b_hs_first = -1, b_hs_last = -1, b_de0 = 0;
  int b_req_x = -1, b_req_y = -1, b_req_line = -1;
  bit b_req_seen = 0, b_ur_seen = 0, mon_on = 1;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && mon_on) begin
        if (b_ls) begin
          if (b_ls_cnt == 1) b_period = cyc - b_ls_prev;
          b_ls_prev = cyc;
          b_ls_cnt++;
        end
        if (b_fs) b_fs_cnt++;
        if (b_hs && b_y == 0) begin
          if (b_hs_first < 0) b_hs_first = b_x;
          b_hs_last = b_x;
        end
        if (b_de && b_y == 0) b_de0++;
        if (b_req && !b_req_seen) begin
          b_req_seen = 1; b_req_x = b_x; b_req_y = b_y; b_req_line = b_line;
        end
        if (b_ur) b_ur_seen = 1;
      end
    end
  end

  initial begin
    int cnt;
    bit ok;
    rst_n = 1'b0;
    b_en = 0; b_clr = 0; s_en = 0; s_ack = 0; s_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_b_hsync", b_hs, 0);
    chk("rst_b_vsync", b_vs, 0);
    chk("rst_s_vsync", s_vs, 1);
    chk("rst_s_de", s_de, 0);
    chk("rst_s_req", s_req, 0);
    rst_n = 1'b1; b_en = 1; s_en = 1;

    // Frame period, DE count and wrap of the reduced timing
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clk);
      ok = s_fs;
    end
    chk("s_first_fs", ok, 1);
    chk("s_first_xy", s_x + s_y, 0);
    cnt = 0;
    for (int i = 0; i < 98; i++) begin
      if (s_de) cnt++;
      if (i == 97) begin
        chk("s_wrap_x13", s_x, 13);
        chk("s_wrap_y6", s_y, 6);
      end
      @(negedge clk);
    end
    chk("s_de_per_frame", cnt, 32);
    chk("s_fs_period", s_fs, 1);

    // ack tied low: underrun at the next line start, then next request as scheduled
    s_clr = 1;
    @(negedge clk);
    s_clr = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin @(negedge clk); ok = s_req; end
    chk("s_req1_seen", ok, 1);
    chk("s_req1_x", s_x, 8);
    chk("s_req1_y", s_y, 0);
    chk("s_req1_line", s_line, 1);
    chk("s_req1_ur", s_ur, 0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = s_ls; end
    chk("s_ur_at_ls", s_ur, 1);
    chk("s_ur_req_drop", s_req, 0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = s_req; end
    chk("s_req2_x", s_x, 8);
    chk("s_req2_line", s_line, 2);
    s_clr = 1;
    @(negedge clk);
    s_clr = 0;

    // Ack on the deadline cycle is on time
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = s_req && s_x == 13; end
    chk("s_dl_wait", ok, 1);
    s_ack = 1;
    @(negedge clk);
    s_ack = 0;
    chk("s_dl_ack_ur", s_ur, 0);
    chk("s_dl_ack_req", s_req, 0);

    // Clear and set on the same edge: set wins
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = s_req && s_x == 13; end
    chk("s_clrset_wait", ok, 1);
    s_clr = 1;
    @(negedge clk);
    s_clr = 0;
    chk("s_clrset_ur", s_ur, 1);

    // Disable with a request pending, then re-enable
    ok = 0;
    for (int i = 0; i < 120 && !ok; i++) begin @(negedge clk); ok = s_req && s_x == 10; end
    chk("s_dis_wait", ok, 1);
    s_en = 0;
    @(negedge clk);
    chk("s_dis_req", s_req, 0);
    chk("s_dis_xy", s_x + s_y, 0);
    chk("s_dis_hs", s_hs, 0);
    chk("s_dis_vs", s_vs, 1);
    chk("s_dis_ur_kept", s_ur, 1);
    s_en = 1;
    @(negedge clk);
    chk("s_reen_fs", s_fs, 1);
    chk("s_reen_xy", s_x + s_y, 0);

    // Random handshake, clear and enable traffic
    for (int i = 0; i < 3000; i++) begin
      s_ack = ($urandom_range(0, 3) == 0);
      s_clr = ($urandom_range(0, 49) == 0);
      s_en  = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    s_ack = 0; s_clr = 0; s_en = 1;
    mon_on = 0;

    chk("b_line_period", b_period, 1056);
    chk("b_hsync_first_x", b_hs_first, 840);
    chk("b_hsync_last_x", b_hs_last, 967);
    chk("b_de_line0", b_de0, 800);
    chk("b_req_x", b_req_x, 800);
    chk("b_req_y", b_req_y, 0);
    chk("b_req_line", b_req_line, 1);
    chk("b_underrun", b_ur_seen, 0);
    chk("b_one_frame_start", b_fs_cnt, 1);

    // Asynchronous reset in the middle of a fetch
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = s_req; end
    chk("s_arst_wait", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("s_arst_req", s_req, 0);
    chk("s_arst_x", s_x, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
